alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (32-bit, 3-bit ALUControl) between two requesters, A and B.
- Arbitration is round-robin. Each request is a valid/ready handshake; each response is a valid/ready handshake.
- Operands are latched so the ALU sees stable inputs. The result is registered and held until the owning requester accepts it.
- Sits between the execute-stage issue logic and the single ALU instance.

---
 rtl/alu_share_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between two requesters (A and B)
//            using round-robin arbitration. Each request and each response is
//            a valid/ready handshake. Operands are latched on the request
//            handshake so the ALU sees stable inputs. The ALU result is
//            registered and held until the owning requester accepts it.
// Ports    : clk, reset (sync, active-high)
//            ReqValidX/ReqReadyX/ReqSrcAX/ReqSrcBX/ReqCtrlX  request side, X=A,B
//            RspValidX/RspReadyX                             response side, X=A,B
//            RspResult/RspError     shared response data, qualified by RspValidX
//            SrcA/SrcB/ALUControl   to the ALU;  ALUResult  from the ALU
//            Busy                   high whenever the FSM is not idle
// Options  : `define ALU_OP_CHECK_EN to flag opcodes 011/101 as illegal at
//            accept time. Illegal ops skip the ALU and answer one cycle early
//            with RspResult=0, RspError=1. Without the macro RspError is 0.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    // requester A
    input  logic             ReqValidA,
    output logic             ReqReadyA,
    input  logic [WIDTH-1:0] ReqSrcAA,
    input  logic [WIDTH-1:0] ReqSrcBA,
    input  logic [2:0]       ReqCtrlA,
    output logic             RspValidA,
    input  logic             RspReadyA,
    // requester B
    input  logic             ReqValidB,
    output logic             ReqReadyB,
    input  logic [WIDTH-1:0] ReqSrcAB,
    input  logic [WIDTH-1:0] ReqSrcBB,
    input  logic [2:0]       ReqCtrlB,
    output logic             RspValidB,
    input  logic             RspReadyB,
    // shared response
    output logic [WIDTH-1:0] RspResult,
    output logic             RspError,
    // ALU interface
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    // status
    output logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Requester encoding used by owner / last-grant registers: 0 = A, 1 = B
    localparam logic c_REQ_A = 1'b0;
    localparam logic c_REQ_B = 1'b1;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_src_a;
    logic [WIDTH-1:0] r_src_b;
    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_result;

    logic             w_idle;
    logic             w_grant_b;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_src_a;
    logic [WIDTH-1:0] w_sel_src_b;
    logic [2:0]       w_sel_ctrl;
    logic             w_owner_ready;

    // Reset gates the request handshake so nothing is accepted while the
    // state register is being forced back to idle.
    assign w_idle = (r_state == S_IDLE) && !reset;

    // B wins when it is the only requester, or when both request and A was
    // the last one served.
    assign w_grant_b = ReqValidB && (!ReqValidA || (r_last_grant == c_REQ_A));
    assign w_accept  = w_idle && (ReqValidA || ReqValidB);

    assign ReqReadyA = w_idle && ReqValidA && !w_grant_b;
    assign ReqReadyB = w_idle && w_grant_b;

    assign w_sel_src_a = w_grant_b ? ReqSrcAB : ReqSrcAA;
    assign w_sel_src_b = w_grant_b ? ReqSrcBB : ReqSrcBA;
    assign w_sel_ctrl  = w_grant_b ? ReqCtrlB : ReqCtrlA;

    // Only the owner's ready completes the response; the other one is ignored.
    assign w_owner_ready = (r_owner == c_REQ_B) ? RspReadyB : RspReadyA;

`ifdef ALU_OP_CHECK_EN
    logic r_error;
    logic w_illegal;

    assign w_illegal = (w_sel_ctrl == 3'b011) || (w_sel_ctrl == 3'b101);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_REQ_B;   // A wins the first contention
            r_owner      <= c_REQ_A;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_ctrl       <= 3'b000;
            r_result     <= '0;
`ifdef ALU_OP_CHECK_EN
            r_error      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant_b;
`ifdef ALU_OP_CHECK_EN
                        if (w_illegal) begin
                            // Answer straight away; the ALU operand
                            // registers keep their previous contents.
                            r_result <= '0;
                            r_error  <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_src_a <= w_sel_src_a;
                            r_src_b <= w_sel_src_b;
                            r_ctrl  <= w_sel_ctrl;
                            r_state <= S_EXEC;
                        end
`else
                        r_src_a <= w_sel_src_a;
                        r_src_b <= w_sel_src_b;
                        r_ctrl  <= w_sel_ctrl;
                        r_state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    r_result <= ALUResult;
`ifdef ALU_OP_CHECK_EN
                    r_error  <= 1'b0;
`endif
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_owner_ready) begin
                        r_last_grant <= r_owner;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign SrcA       = r_src_a;
    assign SrcB       = r_src_b;
    assign ALUControl = r_ctrl;

    assign RspResult = r_result;
`ifdef ALU_OP_CHECK_EN
    assign RspError  = r_error;
`else
    assign RspError  = 1'b0;
`endif

    assign RspValidA = (r_state == S_RESP) && (r_owner == c_REQ_A);
    assign RspValidB = (r_state == S_RESP) && (r_owner == c_REQ_B);
    assign Busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter. A behavioural ALU
//            model drives ALUResult from SrcA/SrcB/ALUControl. Single-op
//            vectors come from a table; arbitration, backpressure and
//            mid-operation reset are hand-written sequences.
// Options  : honours `ALU_OP_CHECK_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             ReqValidA, ReqReadyA, RspValidA, RspReadyA;
    logic             ReqValidB, ReqReadyB, RspValidB, RspReadyB;
    logic [WIDTH-1:0] ReqSrcAA, ReqSrcBA, ReqSrcAB, ReqSrcBB;
    logic [2:0]       ReqCtrlA, ReqCtrlB;
    logic [WIDTH-1:0] RspResult;
    logic             RspError;
    logic [WIDTH-1:0] SrcA, SrcB, ALUResult;
    logic [2:0]       ALUControl;
    logic             Busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ReqValidA  (ReqValidA),
        .ReqReadyA  (ReqReadyA),
        .ReqSrcAA   (ReqSrcAA),
        .ReqSrcBA   (ReqSrcBA),
        .ReqCtrlA   (ReqCtrlA),
        .RspValidA  (RspValidA),
        .RspReadyA  (RspReadyA),
        .ReqValidB  (ReqValidB),
        .ReqReadyB  (ReqReadyB),
        .ReqSrcAB   (ReqSrcAB),
        .ReqSrcBB   (ReqSrcBB),
        .ReqCtrlB   (ReqCtrlB),
        .RspValidB  (RspValidB),
        .RspReadyB  (RspReadyB),
        .RspResult  (RspResult),
        .RspError   (RspError),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Busy       (Busy)
    );

    // Behavioural ALU: SLT is an unsigned compare, 011/101 give 0.
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            3'b000:  ALUResult = SrcA & SrcB;
            3'b001:  ALUResult = SrcA | SrcB;
            3'b010:  ALUResult = SrcA + SrcB;
            3'b110:  ALUResult = SrcA - SrcB;
            3'b100:  ALUResult = SrcA ^ SrcB;
            3'b111:  ALUResult = {31'd0, (SrcA < SrcB)};
            default: ALUResult = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          who;   // 0 = A, 1 = B
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic idle_inputs();
        ReqValidA = 1'b0; ReqValidB = 1'b0;
        ReqSrcAA  = '0;   ReqSrcBA  = '0;   ReqCtrlA = 3'b000;
        ReqSrcAB  = '0;   ReqSrcBB  = '0;   ReqCtrlB = 3'b000;
        RspReadyA = 1'b1; RspReadyB = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One isolated operation; caller leaves the DUT idle at a negedge.
    task automatic run_vec(input int idx, input vec_t v);
        bit illegal;
        logic rv_own, rv_oth;
        illegal = 1'b0;
`ifdef ALU_OP_CHECK_EN
        illegal = (v.ctrl == 3'b011) || (v.ctrl == 3'b101);
`endif
        // cycle 0: handshake
        if (v.who) begin
            ReqValidB = 1'b1; ReqSrcAB = v.a; ReqSrcBB = v.b; ReqCtrlB = v.ctrl;
        end else begin
            ReqValidA = 1'b1; ReqSrcAA = v.a; ReqSrcBA = v.b; ReqCtrlA = v.ctrl;
        end
        #1;
        check($sformatf("vec%0d ready_owner", idx), v.who ? ReqReadyB : ReqReadyA, 1);
        check($sformatf("vec%0d ready_other", idx), v.who ? ReqReadyA : ReqReadyB, 0);
        // cycle 1: inputs scrambled after handshake must not matter
        @(negedge clk);
        ReqValidA = 1'b0; ReqValidB = 1'b0;
        ReqSrcAA = $urandom; ReqSrcBA = $urandom; ReqSrcAB = $urandom; ReqSrcBB = $urandom;
        #1;
        check($sformatf("vec%0d busy_c1", idx), Busy, 1);
        rv_own = v.who ? RspValidB : RspValidA;
        if (illegal) begin
            check($sformatf("vec%0d rspvalid_c1", idx), rv_own, 1);
            check($sformatf("vec%0d result_c1", idx), RspResult, 0);
            check($sformatf("vec%0d error_c1", idx), RspError, 1);
        end else begin
            check($sformatf("vec%0d rspvalid_c1", idx), rv_own, 0);
            check($sformatf("vec%0d srca_c1", idx), SrcA, v.a);
            check($sformatf("vec%0d ctrl_c1", idx), ALUControl, v.ctrl);
            // cycle 2: response
            @(negedge clk);
            #1;
            rv_own = v.who ? RspValidB : RspValidA;
            rv_oth = v.who ? RspValidA : RspValidB;
            check($sformatf("vec%0d rspvalid_c2", idx), rv_own, 1);
            check($sformatf("vec%0d rspvalid_other", idx), rv_oth, 0);
            check($sformatf("vec%0d result", idx), RspResult, v.exp);
            check($sformatf("vec%0d error", idx), RspError, 0);
            check($sformatf("vec%0d busy_c2", idx), Busy, 1);
        end
        @(negedge clk);
        #1;
        check($sformatf("vec%0d busy_done", idx), Busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        vecs[0] = '{1'b0, 3'b010, 32'd5,         32'd7,         32'd12};
        vecs[1] = '{1'b0, 3'b111, 32'd3,         32'd9,         32'd1};
        vecs[2] = '{1'b0, 3'b100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[3] = '{1'b1, 3'b001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF};
        vecs[4] = '{1'b0, 3'b011, 32'd8,         32'd4,         32'd0};
        vecs[5] = '{1'b1, 3'b101, 32'd6,         32'd2,         32'd0};
        vecs[6] = '{1'b1, 3'b111, 32'd9,         32'd3,         32'd0};
        vecs[7] = '{1'b0, 3'b110, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[8] = '{1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[9] = '{1'b1, 3'b000, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030};

        // ---- reset state ----
        do_reset();
        #1;
        check("rst busy",      Busy, 0);
        check("rst rspvalidA", RspValidA, 0);
        check("rst rspvalidB", RspValidB, 0);
        check("rst readyA",    ReqReadyA, 0);
        check("rst readyB",    ReqReadyB, 0);
        check("rst srca",      SrcA, 0);
        check("rst srcb",      SrcB, 0);
        check("rst ctrl",      ALUControl, 0);
        check("rst result",    RspResult, 0);
        check("rst error",     RspError, 0);

        // ---- table-driven single operations ----
        @(negedge clk);
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // ---- contention after reset: strict A,B alternation ----
        do_reset();
        ReqValidA = 1'b1; ReqCtrlA = 3'b110; ReqSrcAA = 32'd10;   ReqSrcBA = 32'd3;
        ReqValidB = 1'b1; ReqCtrlB = 3'b000; ReqSrcAB = 32'hF0;   ReqSrcBB = 32'h3C;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d readyA", k), ReqReadyA, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d readyB", k), ReqReadyB, (k % 2 == 1) ? 1 : 0);
            @(negedge clk);
            @(negedge clk);
            #1;
            check($sformatf("rr%0d rspvalidA", k), RspValidA, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d rspvalidB", k), RspValidB, (k % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d result", k), RspResult, (k % 2 == 0) ? 32'd7 : 32'h30);
            @(negedge clk);
        end
        ReqValidA = 1'b0; ReqValidB = 1'b0;

        // ---- response backpressure on B; A waits, A's ready ignored ----
        do_reset();
        ReqValidB = 1'b1; ReqCtrlB = 3'b001; ReqSrcAB = 32'h0F; ReqSrcBB = 32'hF0;
        RspReadyB = 1'b0; RspReadyA = 1'b1;
        #1;
        check("bp readyB", ReqReadyB, 1);
        @(negedge clk);
        ReqValidB = 1'b0;
        ReqValidA = 1'b1; ReqCtrlA = 3'b010; ReqSrcAA = 32'd1; ReqSrcBA = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d rspvalidB", i), RspValidB, 1);
            check($sformatf("bp%0d result", i), RspResult, 32'hFF);
            check($sformatf("bp%0d readyA", i), ReqReadyA, 0);
            check($sformatf("bp%0d rspvalidA", i), RspValidA, 0);
        end
        @(negedge clk);
        RspReadyB = 1'b1;
        #1;
        check("bp release rspvalidB", RspValidB, 1);
        check("bp release readyA", ReqReadyA, 0);
        @(negedge clk);
        RspReadyB = 1'b0;
        #1;
        check("bp after readyA", ReqReadyA, 1);
        check("bp after rspvalidB", RspValidB, 0);
        @(negedge clk);
        ReqValidA = 1'b0;
        @(negedge clk);
        #1;
        check("bp A rspvalid", RspValidA, 1);
        check("bp A result", RspResult, 32'd2);
        @(negedge clk);

        // ---- reset while in EXEC drops the operation ----
        do_reset();
        ReqValidA = 1'b1; ReqCtrlA = 3'b010; ReqSrcAA = 32'd5; ReqSrcBA = 32'd7;
        #1;
        check("mid readyA", ReqReadyA, 1);
        @(negedge clk);
        ReqValidA = 1'b0;
        #1;
        check("mid busy exec", Busy, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid busy after rst", Busy, 0);
        check("mid rspvalidA", RspValidA, 0);
        check("mid rspvalidB", RspValidB, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("mid%0d no rsp", i), RspValidA | RspValidB, 0);
            check($sformatf("mid%0d idle", i), Busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
